traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Checker that sits on the lamp outputs of the traffic-light controller (green `x`, red `d`, yellow `v`). It tracks which phase the lamps show, measures each phase in clock cycles, enforces one-hot lamps, legal phase order and duration limits, and drives a 7-segment phase/fault display. A violation latches a sticky fault that only `clr` or reset removes.

## Interface
- `G_MIN`, default 6: minimum green length in cycles.
- `Y_LEN`, default 2: exact required yellow length in cycles.
- `R_MIN`, default 9: minimum red length in cycles.
- `CW`, default 8: width of the phase cycle counter.
- `ck  in  1`: clock, rising edge.
- `rs  in  1`: reset, asynchronous, active-low.
- `en  in  1`: monitor enable; low holds the monitor idle.
- `clr  in  1`: synchronous fault clear, one-cycle pulse.
- `x  in  1`: green lamp, active-high, synchronous to `ck`.
- `d  in  1`: red lamp, active-high, synchronous to `ck`.
- `v  in  1`: yellow lamp, active-high, synchronous to `ck`.
- `phase  out  2`: 0 idle, 1 green, 2 yellow, 3 red.
- `cnt  out  CW`: consecutive sampled cycles of the current phase; saturates at all-ones.
- `rounds  out  8`: completed green→yellow→red→green rounds; wraps 255→0.
- `fault  out  1`: sticky violation flag.
- `fcode  out  3`: first violation cause. 0 none, 1 lamps not one-hot, 2 illegal order, 3 yellow length ≠ `Y_LEN`, 4 green < `G_MIN`, 5 red < `R_MIN`.
- `HEX  out  8`: active-low 7-segment, bit order {dp,g,f,e,d,c,b,a}.

## Operation
- States: IDLE, GREEN, YELLOW, RED, FAULT. Lamp vector L = {x,v,d} is sampled on every rising edge.
- Priority on each edge: `clr` > `en` low > checking.
- `clr`=1: go to IDLE. Set `fault`=0, `fcode`=0, `cnt`=0. `rounds` is unchanged.
- `en`=0 and not FAULT: go to IDLE with `cnt`=0. No checks are made. A FAULT state is held.
- IDLE:
  - L=000: stay in IDLE.
  - L one-hot: enter the matching phase with `cnt`=1.
  - L has more than one bit set: FAULT, code 1.
- In GREEN, YELLOW or RED:
  - L not one-hot (including 000): FAULT, code 1.
  - Same lamp: `cnt`+1, saturating.
  - In YELLOW, if `cnt` would exceed `Y_LEN`: FAULT, code 3.
- Lamp changes, in GREEN, YELLOW or RED:
  - Legal order is green→yellow→red→green. Any other change: FAULT, code 2.
  - Legal change, duration checked on the phase being left:
    - leaving GREEN with `cnt` < `G_MIN`: code 4.
    - leaving YELLOW with `cnt` ≠ `Y_LEN`: code 3.
    - leaving RED with `cnt` < `R_MIN`: code 5.
  - Passing all checks: enter the next phase with `cnt`=1.
  - RED→GREEN additionally increments `rounds`.
- Leaving IDLE into a phase never counts as a round.
- FAULT:
  - `phase` and `cnt` freeze at the values held just before the fault.
  - `fault`=1; `fcode` keeps the first cause.
  - Lamp inputs are ignored until `clr`.
- Only one cause is recorded per edge. Code 1 wins over codes 2–5.
- HEX display:
  - idle "-" = 8'hBF
  - green "G" = 8'hC2
  - yellow "Y" = 8'h91
  - red "r" = 8'hAF
  - FAULT "F" = 8'h8E
- Width rule: `cnt` compares against the parameters unsigned, zero-extended to `CW`. If `cnt` saturates, the green and red minimums are satisfied.

## Timing
- All outputs are registered. A lamp value sampled at edge k is reflected on the outputs after edge k; there are no combinational input→output paths.
- Reset (`rs`=0) takes effect immediately, independent of `ck`:
  - state IDLE, `phase`=0, `cnt`=0, `rounds`=0, `fault`=0, `fcode`=0, `HEX`=8'hBF.
- Reset released mid-phase: the monitor starts from IDLE. The partial phase being shown is measured from the first sampled edge.
- `fault` rises on the same edge that samples the violating lamp vector.
- `clr` takes effect on the edge where it is high. Checking resumes on the next edge.
- `clr` and a violation on the same edge: `clr` wins.

## Test plan
- Normal round: reset, then `en`=1 with green 6 cycles, yellow 2, red 9, green 1 → `fault`=0, `rounds`=1, `phase`=1, `cnt`=1, `HEX`=8'hC2.
- Short green: green 5 cycles, then yellow → `fault`=1, `fcode`=4, `phase` stays 1, `cnt`=5, `HEX`=8'h8E.
- Yellow overrun: green 6, then yellow 3 → fault on the 3rd yellow edge, `fcode`=3.
- Illegal order and one-hot: green 6 then red → `fcode`=2. After `clr`, L=110 → `fcode`=1, `phase`=0.
- Clear and enable: `clr` on the same edge as L=111 → `fault`=0, `phase`=0. With `en`=0, any L for 5 cycles → `phase`=0, `cnt`=0.
- Async reset mid-red with `rounds`=3: pull `rs` low between edges → all outputs reset immediately, `rounds`=0, `HEX`=8'hBF.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Lamp-output checker for the traffic-light controller: tracks the displayed
// phase, times it, and latches the first one-hot/order/duration violation.
module traffic_light_monitor #(
  parameter int unsigned G_MIN = 6,
  parameter int unsigned Y_LEN = 2,
  parameter int unsigned R_MIN = 9,
  parameter int unsigned CW    = 8
) (
  input  logic          ck,
  input  logic          rs,
  input  logic          en,
  input  logic          clr,
  input  logic          x,
  input  logic          d,
  input  logic          v,
  output logic [1:0]    phase,
  output logic [CW-1:0] cnt,
  output logic [7:0]    rounds,
  output logic          fault,
  output logic [2:0]    fcode,
  output logic [7:0]    HEX
);

  localparam int unsigned PW = 2;
  localparam int unsigned FW = 3;

  localparam logic [PW-1:0] PH_IDLE   = 2'd0;
  localparam logic [PW-1:0] PH_GREEN  = 2'd1;
  localparam logic [PW-1:0] PH_YELLOW = 2'd2;
  localparam logic [PW-1:0] PH_RED    = 2'd3;

  localparam logic [FW-1:0] FC_NONE   = 3'd0;
  localparam logic [FW-1:0] FC_ONEHOT = 3'd1;
  localparam logic [FW-1:0] FC_ORDER  = 3'd2;
  localparam logic [FW-1:0] FC_YLEN   = 3'd3;
  localparam logic [FW-1:0] FC_GMIN   = 3'd4;
  localparam logic [FW-1:0] FC_RMIN   = 3'd5;

  localparam logic [7:0] HEX_IDLE   = 8'hBF;
  localparam logic [7:0] HEX_GREEN  = 8'hC2;
  localparam logic [7:0] HEX_YELLOW = 8'h91;
  localparam logic [7:0] HEX_RED    = 8'hAF;
  localparam logic [7:0] HEX_FAULT  = 8'h8E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_RED,
    S_FAULT
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   phase_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic [7:0]      rounds_nxt;
  logic            fault_nxt;
  logic [FW-1:0]   fcode_nxt;
  logic [7:0]      hex_nxt;
  logic [FW-1:0]   code;

  logic [2:0]      lamps;
  logic            one_hot;
  state_t          lamp_st;
  state_t          succ_st;
  logic [PW-1:0]   lamp_ph;
  logic            cnt_sat;
  logic [CW-1:0]   cnt_inc;
  logic            green_short;
  logic            red_short;
  logic            yellow_over;
  logic            yellow_bad;

  assign lamps = {x, v, d};

  // Decode the sampled lamp vector into the phase it represents
  always_comb begin
    one_hot = 1'b1;
    lamp_st = S_IDLE;
    lamp_ph = PH_IDLE;
    case (lamps)
      3'b100: begin lamp_st = S_GREEN;  lamp_ph = PH_GREEN;  end
      3'b010: begin lamp_st = S_YELLOW; lamp_ph = PH_YELLOW; end
      3'b001: begin lamp_st = S_RED;    lamp_ph = PH_RED;    end
      default: one_hot = 1'b0;
    endcase
  end

  always_comb begin
    succ_st = S_FAULT;
    case (state)
      S_GREEN:  succ_st = S_YELLOW;
      S_YELLOW: succ_st = S_RED;
      S_RED:    succ_st = S_GREEN;
      default:  succ_st = S_FAULT;
    endcase
  end

  // A saturated counter is treated as long enough for the minimum checks
  assign cnt_sat     = &cnt;
  assign cnt_inc     = cnt_sat ? cnt : cnt + CW'(1);
  assign green_short = !cnt_sat && (32'(cnt) < G_MIN);
  assign red_short   = !cnt_sat && (32'(cnt) < R_MIN);
  assign yellow_over = 32'(cnt) >= Y_LEN;
  assign yellow_bad  = 32'(cnt) != Y_LEN;

  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      state  <= S_IDLE;
      phase  <= PH_IDLE;
      cnt    <= '0;
      rounds <= '0;
      fault  <= 1'b0;
      fcode  <= FC_NONE;
      HEX    <= HEX_IDLE;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      cnt    <= cnt_nxt;
      rounds <= rounds_nxt;
      fault  <= fault_nxt;
      fcode  <= fcode_nxt;
      HEX    <= hex_nxt;
    end
  end

  // Next state: clr beats enable, enable beats checking; one cause per edge
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    cnt_nxt    = cnt;
    rounds_nxt = rounds;
    fault_nxt  = fault;
    fcode_nxt  = fcode;
    code       = FC_NONE;

    if (clr) begin
      state_nxt = S_IDLE;
      phase_nxt = PH_IDLE;
      cnt_nxt   = '0;
      fault_nxt = 1'b0;
      fcode_nxt = FC_NONE;
    end else if (!en && state != S_FAULT) begin
      state_nxt = S_IDLE;
      phase_nxt = PH_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (one_hot) begin
            state_nxt = lamp_st;
            phase_nxt = lamp_ph;
            cnt_nxt   = CW'(1);
          end else if (lamps != 3'b000) begin
            code = FC_ONEHOT;
          end
        end
        S_GREEN, S_YELLOW, S_RED: begin
          if (!one_hot) begin
            code = FC_ONEHOT;
          end else if (lamp_st == state) begin
            if (state == S_YELLOW && yellow_over) code = FC_YLEN;
            else cnt_nxt = cnt_inc;
          end else if (lamp_st != succ_st) begin
            code = FC_ORDER;
          end else if (state == S_GREEN && green_short) begin
            code = FC_GMIN;
          end else if (state == S_YELLOW && yellow_bad) begin
            code = FC_YLEN;
          end else if (state == S_RED && red_short) begin
            code = FC_RMIN;
          end else begin
            state_nxt = lamp_st;
            phase_nxt = lamp_ph;
            cnt_nxt   = CW'(1);
            if (state == S_RED) rounds_nxt = rounds + 8'd1;
          end
        end
        default: ;
      endcase

      // phase and cnt stay frozen at their pre-fault values
      if (code != FC_NONE) begin
        state_nxt = S_FAULT;
        fault_nxt = 1'b1;
        fcode_nxt = code;
      end
    end
  end

  always_comb begin
    hex_nxt = HEX_IDLE;
    case (state_nxt)
      S_GREEN:  hex_nxt = HEX_GREEN;
      S_YELLOW: hex_nxt = HEX_YELLOW;
      S_RED:    hex_nxt = HEX_RED;
      S_FAULT:  hex_nxt = HEX_FAULT;
      default:  hex_nxt = HEX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: hand-computed expectations for
// normal rounds, each violation code, clear/enable priority and async reset.
module tb_traffic_light_monitor;

  localparam int unsigned CW = 8;

  localparam logic [2:0] LG = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b001;
  localparam logic [2:0] LO = 3'b000;

  logic          ck = 1'b0;
  logic          rs;
  logic          en;
  logic          clr;
  logic          x, d, v;
  logic [1:0]    phase;
  logic [CW-1:0] cnt;
  logic [7:0]    rounds;
  logic          fault;
  logic [2:0]    fcode;
  logic [7:0]    HEX;

  int vectors = 0;
  int miscompares = 0;

  traffic_light_monitor #(
    .G_MIN(6), .Y_LEN(2), .R_MIN(9), .CW(CW)
  ) dut (
    .ck(ck), .rs(rs), .en(en), .clr(clr),
    .x(x), .d(d), .v(v),
    .phase(phase), .cnt(cnt), .rounds(rounds),
    .fault(fault), .fcode(fcode), .HEX(HEX)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present lamps {x,v,d} for n rising edges; return 1 time unit after the last
  task automatic step(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      {x, v, d} = l;
      @(posedge ck);
      #1;
    end
  endtask

  task automatic pulse_clr(input logic [2:0] l);
    clr = 1'b1;
    step(l, 1);
    clr = 1'b0;
  endtask

  initial begin
    rs = 1'b0; en = 1'b0; clr = 1'b0; {x, v, d} = LO;
    #12;
    chk("rst_phase",  32'(phase),  32'd0);
    chk("rst_cnt",    32'(cnt),    32'd0);
    chk("rst_rounds", 32'(rounds), 32'd0);
    chk("rst_fault",  32'(fault),  32'd0);
    chk("rst_fcode",  32'(fcode),  32'd0);
    chk("rst_hex",    32'(HEX),    32'hBF);
    #1;
    rs = 1'b1; en = 1'b1;

    // Normal round
    step(LG, 6);
    chk("g6_phase", 32'(phase), 32'd1);
    chk("g6_cnt",   32'(cnt),   32'd6);
    step(LY, 2);
    chk("y2_phase", 32'(phase), 32'd2);
    chk("y2_cnt",   32'(cnt),   32'd2);
    chk("y2_hex",   32'(HEX),   32'h91);
    step(LR, 9);
    chk("r9_phase", 32'(phase), 32'd3);
    chk("r9_cnt",   32'(cnt),   32'd9);
    chk("r9_hex",   32'(HEX),   32'hAF);
    step(LG, 1);
    chk("rnd_fault",  32'(fault),  32'd0);
    chk("rnd_rounds", 32'(rounds), 32'd1);
    chk("rnd_phase",  32'(phase),  32'd1);
    chk("rnd_cnt",    32'(cnt),    32'd1);
    chk("rnd_hex",    32'(HEX),    32'hC2);

    pulse_clr(LG);
    chk("clr1_phase",  32'(phase),  32'd0);
    chk("clr1_cnt",    32'(cnt),    32'd0);
    chk("clr1_rounds", 32'(rounds), 32'd1);

    // Short green
    step(LG, 5);
    step(LY, 1);
    chk("sg_fault", 32'(fault), 32'd1);
    chk("sg_fcode", 32'(fcode), 32'd4);
    chk("sg_phase", 32'(phase), 32'd1);
    chk("sg_cnt",   32'(cnt),   32'd5);
    chk("sg_hex",   32'(HEX),   32'h8E);
    pulse_clr(LO);
    chk("clr2_fault", 32'(fault), 32'd0);
    chk("clr2_fcode", 32'(fcode), 32'd0);
    chk("clr2_hex",   32'(HEX),   32'hBF);

    // Yellow overrun: third yellow edge faults
    step(LG, 6);
    step(LY, 2);
    chk("yo2_fault", 32'(fault), 32'd0);
    step(LY, 1);
    chk("yo3_fault", 32'(fault), 32'd1);
    chk("yo3_fcode", 32'(fcode), 32'd3);
    chk("yo3_phase", 32'(phase), 32'd2);
    chk("yo3_cnt",   32'(cnt),   32'd2);
    pulse_clr(LO);

    // Illegal order green -> red
    step(LG, 6);
    step(LR, 1);
    chk("ord_fcode", 32'(fcode), 32'd2);
    chk("ord_phase", 32'(phase), 32'd1);
    chk("ord_cnt",   32'(cnt),   32'd6);

    // clr wins over a same-edge violation, then one-hot from idle
    pulse_clr(3'b111);
    chk("clrv_fault", 32'(fault), 32'd0);
    chk("clrv_phase", 32'(phase), 32'd0);
    step(3'b110, 1);
    chk("oh_fault", 32'(fault), 32'd1);
    chk("oh_fcode", 32'(fcode), 32'd1);
    chk("oh_phase", 32'(phase), 32'd0);
    step(LG, 1);
    chk("oh_sticky_fcode", 32'(fcode), 32'd1);
    chk("oh_sticky_phase", 32'(phase), 32'd0);
    en = 1'b0;
    step(LO, 2);
    chk("en0_fault_held", 32'(fault), 32'd1);
    pulse_clr(LO);
    chk("en0_clr_fault", 32'(fault), 32'd0);
    step(3'b111, 1);
    step(LG, 1);
    step(LY, 1);
    step(3'b011, 1);
    step(LR, 1);
    chk("en0_phase", 32'(phase), 32'd0);
    chk("en0_cnt",   32'(cnt),   32'd0);
    chk("en0_fault", 32'(fault), 32'd0);
    en = 1'b1;

    // Yellow too short when leaving
    step(LG, 6);
    step(LY, 1);
    step(LR, 1);
    chk("ys_fcode", 32'(fcode), 32'd3);
    chk("ys_phase", 32'(phase), 32'd2);
    chk("ys_cnt",   32'(cnt),   32'd1);
    pulse_clr(LO);

    // Short red, entered straight from idle
    step(LR, 8);
    step(LG, 1);
    chk("sr_fcode",  32'(fcode),  32'd5);
    chk("sr_phase",  32'(phase),  32'd3);
    chk("sr_cnt",    32'(cnt),    32'd8);
    chk("sr_rounds", 32'(rounds), 32'd1);
    pulse_clr(LO);

    // Counter saturation, then red -> green counts a round
    step(LR, 260);
    chk("sat_cnt",   32'(cnt),   32'hFF);
    chk("sat_fault", 32'(fault), 32'd0);
    step(LG, 1);
    chk("sat_rounds", 32'(rounds), 32'd2);
    chk("sat_fault2", 32'(fault),  32'd0);
    step(LG, 5);
    step(LY, 2);
    step(LR, 9);
    step(LG, 1);
    chk("r3_rounds", 32'(rounds), 32'd3);

    // Async reset mid-red
    step(LG, 5);
    step(LY, 2);
    step(LR, 4);
    chk("mr_phase", 32'(phase), 32'd3);
    chk("mr_cnt",   32'(cnt),   32'd4);
    #2;
    rs = 1'b0;
    #1;
    chk("ar_phase",  32'(phase),  32'd0);
    chk("ar_cnt",    32'(cnt),    32'd0);
    chk("ar_rounds", 32'(rounds), 32'd0);
    chk("ar_fault",  32'(fault),  32'd0);
    chk("ar_fcode",  32'(fcode),  32'd0);
    chk("ar_hex",    32'(HEX),    32'hBF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
